// File: rtl/matrix_result_collector.sv
// Collects an out-of-order M x N result stream into a buffer, then replays it over valid/ready.
// Define COLLECT_TRANSPOSE_EN to drain column-major instead of row-major.
module matrix_result_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int M          = 4,
    parameter int N          = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     c_data,
    input  logic [$clog2(M)-1:0]      c_row,
    input  logic [$clog2(N)-1:0]      c_col,
    input  logic                      c_valid,
    input  logic                      c_done,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [$clog2(M)-1:0]      out_row,
    output logic [$clog2(N)-1:0]      out_col,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      complete,
    output logic                      busy,
    output logic [$clog2(M*N+1)-1:0]  count,
    output logic                      err_dup,
    output logic                      err_range,
    output logic                      err_missing,
    output logic [1:0]                dbg_state
);
    localparam int RW = $clog2(M);
    localparam int KW = $clog2(N);
    localparam int E  = M * N;
    localparam int AW = $clog2(E);
    localparam int CW = $clog2(E + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] mem [E];
    logic [E-1:0]          bitmap, wr_mask, bitmap_next;
    logic [RW-1:0]         d_row;
    logic [KW-1:0]         d_col;
    logic [AW-1:0]         wr_idx, rd_idx;
    logic                  in_range, wr_en, is_dup, full_next, beat, last_idx;

    assign in_range    = (32'(c_row) < M) && (32'(c_col) < N);
    assign wr_idx      = AW'(32'(c_row) * N + 32'(c_col));
    assign wr_en       = (state == COLLECT) && !start && c_valid && in_range;
    assign wr_mask     = wr_en ? (E'(1) << wr_idx) : '0;
    assign is_dup      = |(bitmap & wr_mask);
    assign bitmap_next = bitmap | wr_mask;
    assign full_next   = &bitmap_next;

    // Drain handshake: a beat transfers on a cycle where out_valid && out_ready.
    // While out_valid is high and out_ready low, data/row/col/last hold; out_valid
    // never drops without a transfer except when start aborts the drain.
    assign rd_idx    = AW'(32'(d_row) * N + 32'(d_col));
    assign last_idx  = (32'(d_row) == M - 1) && (32'(d_col) == N - 1);
    assign out_valid = (state == DRAIN);
    assign beat      = out_valid && out_ready;
    assign out_row   = out_valid ? d_row : '0;
    assign out_col   = out_valid ? d_col : '0;
    assign out_last  = out_valid && last_idx;
    assign out_data  = (out_valid && bitmap[rd_idx]) ? mem[rd_idx] : '0;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = COLLECT;
            COLLECT: begin
                if (start)                      state_next = COLLECT;
                else if (full_next || c_done)   state_next = DRAIN;
            end
            DRAIN: begin
                if (start)                      state_next = COLLECT;
                else if (beat && last_idx)      state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bitmap      <= '0;
            count       <= '0;
            err_dup     <= 1'b0;
            err_range   <= 1'b0;
            err_missing <= 1'b0;
            complete    <= 1'b0;
            d_row       <= '0;
            d_col       <= '0;
        end else begin
            complete <= 1'b0;
            if (start) begin
                bitmap      <= '0;
                count       <= '0;
                err_dup     <= 1'b0;
                err_range   <= 1'b0;
                err_missing <= 1'b0;
                d_row       <= '0;
                d_col       <= '0;
            end else if (state == COLLECT) begin
                bitmap <= bitmap_next;
                if (c_valid && !in_range) err_range <= 1'b1;
                if (wr_en) begin
                    if (is_dup) err_dup <= 1'b1;
                    else        count   <= count + CW'(1);
                end
                if (full_next)   complete    <= 1'b1;
                else if (c_done) err_missing <= 1'b1;
            end else if (state == DRAIN && beat) begin
                if (last_idx) begin
                    d_row <= '0;
                    d_col <= '0;
                end else begin
`ifdef COLLECT_TRANSPOSE_EN
                    if (32'(d_row) == M - 1) begin
                        d_row <= '0;
                        d_col <= d_col + KW'(1);
                    end else begin
                        d_row <= d_row + RW'(1);
                    end
`else
                    if (32'(d_col) == N - 1) begin
                        d_col <= '0;
                        d_row <= d_row + RW'(1);
                    end else begin
                        d_col <= d_col + KW'(1);
                    end
`endif
                end
            end
        end
    end

    // Buffer contents need no reset; the bitmap decides what is meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= c_data;
    end
endmodule
